// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit instruction
//   words and writes them to instruction memory from word address 0 upward.
//   The CPU is held off via cpu_hold until the whole program image is written.
// Ports: clk/rst (async active-high); start + num_words request a load;
//   in_valid/in_data/in_ready byte handshake; mem_we/mem_addr/mem_wdata write
//   port; cpu_hold, busy, done status; err flags an out-of-range num_words.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] num_lat;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [31:0]     asm_word;

  logic start_ok;
  logic num_bad;
  logic num_zero;
  logic byte_acc;
  logic last_word;

  // start is only honoured once the previous load has finished (or never began)
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign num_bad   = (num_words > DEPTH_W);
  assign num_zero  = (num_words == '0);
  assign byte_acc  = in_valid && (state == RECV);
  assign last_word = (word_cnt == (num_lat - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok && !num_bad) begin
          state_nxt = num_zero ? DONE : RECV;
        end
      end
      RECV: begin
        if (byte_acc && (byte_cnt == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = last_word ? DONE : RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      num_lat  <= '0;
      word_cnt <= '0;
      byte_cnt <= 2'd0;
      asm_word <= 32'd0;
    end else begin
      if (start_ok) begin
        err <= num_bad;
        if (!num_bad && !num_zero) begin
          num_lat  <= num_words;
          word_cnt <= '0;
          byte_cnt <= 2'd0;
        end
      end
      if (byte_acc) begin
        asm_word[{byte_cnt, 3'b000} +: 8] <= in_data;
        byte_cnt <= byte_cnt + 2'd1;
      end
      // word_cnt stays on the last address after the final write, so it
      // never exceeds DEPTH-1 and mem_addr never wraps
      if ((state == WRITE) && !last_word) begin
        word_cnt <= word_cnt + ONE;
      end
    end
  end

  assign in_ready  = (state == RECV);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = word_cnt[ADDR_W-1:0];
  assign mem_wdata = asm_word;
  assign cpu_hold  = (state != DONE);
  assign busy      = (state == RECV) || (state == WRITE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  wr_cnt   = 0;
  int  wr_cyc[$];
  int  last_addr = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard, plus the in_ready-vs-WRITE relation while busy
  always @(negedge clk) begin
    if (!rst && busy) check("in_ready_vs_write", {31'd0, in_ready}, {31'd0, !mem_we});
    if (!rst && mem_we) begin
      wr_t e;
      wr_cnt++;
      wr_cyc.push_back(cyc);
      last_addr = int'(mem_addr);
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_we observed addr=%0d data=0x%08h expected no write", mem_addr, mem_wdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic start_load(input int n);
    start = 1'b1;
    num_words = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    sb.push_back({ADDR_W'(a), d});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    if (wr_cyc.size() != 0) check({tag, "_done_lat"}, cyc, wr_cyc[$] + 1);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,        32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_err"},      {31'd0, err},      32'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Out-of-range count: flag error, stay idle with CPU held
    start_load(DEPTH + 1);
    @(negedge clk);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_hold", {31'd0, cpu_hold}, 32'd1);
    check("oor_busy", {31'd0, busy}, 32'd0);
    check("oor_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // Zero-word load: straight to DONE, clears err, no writes
    w0 = wr_cnt;
    start_load(0);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_err_clr", {31'd0, err}, 32'd0);
    check("zero_hold", {31'd0, cpu_hold}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_we", wr_cnt, w0);
    @(posedge clk); #1;

    // Streaming load of two words, in_valid held high
    wr_cyc.delete();
    w0 = wr_cnt;
    push_exp(0, 32'h12345678);
    push_exp(1, 32'hDEADBEEF);
    start_load(2);
    @(negedge clk);
    check("stream_hold", {31'd0, cpu_hold}, 32'd1);
    check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send_word(32'h12345678, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    in_valid = 1'b0;
    wait_done("stream");
    check("stream_wr_cnt", wr_cnt - w0, 32'd2);
    if (wr_cyc.size() == 2) check("stream_spacing", wr_cyc[1] - wr_cyc[0], 32'd5);

    // Stalled stream (reload from DONE), in_valid toggling
    wr_cyc.delete();
    w0 = wr_cnt;
    push_exp(0, 32'h12345678);
    push_exp(1, 32'hDEADBEEF);
    start_load(2);
    @(negedge clk);
    check("stall_hold", {31'd0, cpu_hold}, 32'd1);
    @(posedge clk); #1;
    send_word(32'h12345678, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
    in_valid = 1'b0;
    wait_done("stall");
    repeat (4) @(negedge clk);
    check("stall_wr_cnt", wr_cnt - w0, 32'd2);

    // Full-depth load: last address DEPTH-1, no wrap
    wr_cyc.delete();
    w0 = wr_cnt;
    @(posedge clk); #1;
    start_load(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      d = {8'(i), 8'(~i), 8'(i + 3), 8'h5A};
      push_exp(i, d);
      send_word(d, 1'b0);
    end
    in_valid = 1'b0;
    wait_done("full");
    check("full_wr_cnt", wr_cnt - w0, DEPTH);
    check("full_last_addr", last_addr, DEPTH - 1);

    // Disturbance: start mid-RECV ignored, then async reset mid-word
    wr_cyc.delete();
    w0 = wr_cnt;
    @(posedge clk); #1;
    push_exp(0, 32'hA1B2C3D4);
    start_load(2);
    send_byte(8'hD4);
    send_byte(8'hC3);
    in_valid = 1'b0;
    start = 1'b1;
    num_words = (ADDR_W+1)'(1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_start_busy", {31'd0, busy}, 32'd1);
    check("ign_start_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    send_byte(8'hB2);
    send_byte(8'hA1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ign_start_still_busy", {31'd0, busy}, 32'd1);
    check("ign_start_wr_cnt", wr_cnt - w0, 32'd1);
    @(posedge clk); #1;
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_partial_we", wr_cnt - w0, 32'd1);
    check("rst_sb_empty", sb.size(), 32'd0);

    // Fresh one-word load after reset
    @(posedge clk); #1;
    push_exp(0, 32'hCAFEF00D);
    start_load(1);
    send_word(32'hCAFEF00D, 1'b0);
    in_valid = 1'b0;
    wait_done("post_rst");

    // Reload from DONE with a single word
    wr_cyc.delete();
    w0 = wr_cnt;
    @(posedge clk); #1;
    push_exp(0, 32'h00000001);
    start_load(1);
    @(negedge clk);
    check("reload_hold", {31'd0, cpu_hold}, 32'd1);
    check("reload_done_low", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    send_word(32'h00000001, 1'b0);
    in_valid = 1'b0;
    wait_done("reload");
    check("reload_wr_cnt", wr_cnt - w0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something above never returns
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
